alu_issue: RTL and testbench
============================

# alu_issue

Sequential issue-and-capture stage that drives the 32-bit ALU from the instruction side. Accepts an instruction word plus register-file operand values over a valid/ready handshake, decodes opcode/funct into the ALU's 4-bit `S_Op` selector, and registers `Op1`/`Op2`/`S_Op` toward the ALU. It then captures the ALU's `R_Op`/`ZF` one cycle later and presents a registered result to writeback/branch logic.

## Interface
- No parameters; all widths fixed (32-bit data, 4-bit `S_Op`).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: instruction/operands valid.
- `in_ready` out 1: stage can accept; high only in IDLE.
- `instr` in 32: MIPS-format instruction word.
- `rs_val` in 32: GPR[rs].
- `rt_val` in 32: GPR[rt].
- `Op1` out 32: to ALU, registered.
- `Op2` out 32: to ALU, registered.
- `S_Op` out 4: to ALU, registered.
- `R_Op` in 32: ALU result, combinational from `Op1`/`Op2`/`S_Op`.
- `ZF` in 1: ALU zero flag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `result` out 32: captured `R_Op`.
- `zero` out 1: captured `ZF`.
- `branch_taken` out 1: BEQ and ZF.
- `illegal` out 1: unsupported opcode/funct.
- `div_zero` out 1: DIV with `rt_val`==0.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
  - IDLE→EXEC on `in_valid`&&`in_ready`.
  - EXEC→DONE unconditionally.
  - DONE→IDLE on `out_ready`.
- **Decode on accept** (registered into `Op1`/`Op2`/`S_Op`):
  - **R-type (opcode 000000), by funct:**
    - ADD 100000→0000
    - SUB 100010→0001
    - MULT 011000→0010
    - DIV 011010→0011
    - OR 100101→0100
    - AND 100100→0101
    - SLT 101010→0110
    - SLL/NOP 000000→0111
  - R-type operands: `Op1`=`rs_val`, `Op2`=`rt_val`.
  - **I-type immediates:** the ALU's fixed-constant codes 1000–1011 are never issued. The immediate goes in `Op2`:
    - ADDI 001000→0000, sign-extended imm.
    - SLTI 001010→0110, sign-extended imm.
    - ANDI 001100→0101, zero-extended imm.
    - ORI 001101→0100, zero-extended imm.
  - **Memory:** LW 100011 and SW 101011→0000 (ADD), `Op1`=`rs_val`, `Op2`=sign-extended offset.
  - **BEQ 000100**→0001 (SUB), `Op1`=`rs_val`, `Op2`=`rt_val`; sets internal is_beq.
  - **Any other opcode/funct:** `S_Op`=0111, `Op1`=`Op2`=0, illegal flag set.
- **DIV with `rt_val`==0:** issue `S_Op`=0111 with zero operands (the ALU never sees /0) and set the div_zero flag.
- **EXEC:** capture `R_Op`→`result` and `ZF`→`zero`; `branch_taken`=is_beq&&`ZF`.
  - When div_zero is set, `result`=32'hFFFF_FFFF instead of `R_Op`.
  - `illegal`/`div_zero` latch with the result.
- **DONE:** `result`, `zero`, `branch_taken`, `illegal` and `div_zero` are held stable until the handshake completes.
- **Arithmetic:** modulo 2^32, unsigned, per the ALU. SLT/SLTI compare unsigned. MULT returns the low 32 bits.

## Timing
- Accept at edge N. `Op1`/`Op2`/`S_Op` are valid after N. `result` is captured at N+1. `out_valid` is high from N+1 until the edge where `out_ready` is sampled high.
- Minimum 3 cycles per instruction. No overlap: `in_ready`=0 in EXEC and DONE.
- `out_ready` held high in DONE: returns to IDLE next edge. A new accept is possible at the following edge (`in_ready` is registered from state).
- `in_valid` while not ready: ignored; `instr`/`rs_val`/`rt_val` are not sampled.
- **Reset (sync, `rst_n`=0 at an edge) from any state, including mid-EXEC:**
  - State→IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `Op1`=`Op2`=0, `S_Op`=0111.
  - `result`=0, `zero`=0, `branch_taken`=0, `illegal`=0, `div_zero`=0.
- `Op1`/`Op2`/`S_Op` hold their last values outside EXEC.

## Structure
- **Shared package/header `alu_pkg`:**
  - `S_Op` localparams (ALU_ADD…ALU_ORI, 0000–1011).
  - Opcode and funct constants.
  - FSM state encodings.
- The ALU's decoder must use the same `S_Op` constants.
- **Sub-module `alu_decode`:** combinational `instr`/`rs_val`/`rt_val` → op1/op2/s_op/is_beq/illegal/div_zero. The top holds the FSM and registers.
- Bench instantiates the existing ALU, connected to `alu_issue`.

## Test plan
- **ADDI:** `instr`=ADDI imm 16'hFFFF, `rs_val`=5 → `S_Op`=0000, `Op2`=32'hFFFF_FFFF; `result`=4, `zero`=0, `out_valid` at N+1.
- **BEQ taken / not taken:** `rs_val`=`rt_val`=32'h1234 → `S_Op`=0001, `zero`=1, `branch_taken`=1. Then `rt_val`=32'h1235 → `branch_taken`=0, `result`=32'hFFFF_FFFF.
- **DIV by zero:** `rs_val`=7, `rt_val`=0 → `S_Op`=0111, `div_zero`=1, `result`=32'hFFFF_FFFF. Then DIV 100/7 → `result`=14, `div_zero`=0.
- **Backpressure:** hold `out_ready`=0 for 4 cycles after `out_valid` → `result` stable, `in_ready`=0, `in_valid` pulses ignored. Release → IDLE next edge.
- **Illegal opcode** 111111 → `S_Op`=0111, `illegal`=1, `result`=0, `zero`=1.
- **Reset mid-EXEC:** `rst_n`=0 one cycle after accept → next edge `out_valid`=0, `in_ready`=1, `S_Op`=0111, all flags 0. No result emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU selector codes, MIPS opcode/funct constants and issue-stage FSM states.
// The ALU decoder and the issue stage both take their encodings from here.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MULT = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    // Fixed-constant ALU ops; the issue stage never selects these.
    localparam logic [3:0] ALU_ADDI = 4'b1000;
    localparam logic [3:0] ALU_SLTI = 4'b1001;
    localparam logic [3:0] ALU_ANDI = 4'b1010;
    localparam logic [3:0] ALU_ORI  = 4'b1011;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of a MIPS instruction plus operands into ALU operands and selector.
// Unsupported encodings and divide-by-zero both collapse to a harmless SLL of zeros.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [3:0]  s_op,
    output logic        is_beq,
    output logic        illegal,
    output logic        div_zero
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;
    logic        unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm_sx        = {{16{instr[15]}}, instr[15:0]};
    assign imm_zx        = {16'h0000, instr[15:0]};
    assign unused_fields = ^{instr[25:16], instr[10:6]};

    always_comb begin
        op1      = '0;
        op2      = '0;
        s_op     = ALU_SLL;
        is_beq   = 1'b0;
        illegal  = 1'b0;
        div_zero = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                op1 = rs_val;
                op2 = rt_val;
                case (funct)
                    FN_ADD:  s_op = ALU_ADD;
                    FN_SUB:  s_op = ALU_SUB;
                    FN_MULT: s_op = ALU_MULT;
                    FN_DIV: begin
                        if (rt_val == '0) begin
                            op1      = '0;
                            op2      = '0;
                            div_zero = 1'b1;
                        end else begin
                            s_op = ALU_DIV;
                        end
                    end
                    FN_OR:   s_op = ALU_OR;
                    FN_AND:  s_op = ALU_AND;
                    FN_SLT:  s_op = ALU_SLT;
                    FN_SLL:  s_op = ALU_SLL;
                    default: begin
                        op1     = '0;
                        op2     = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin
                op1  = rs_val;
                op2  = imm_sx;
                s_op = ALU_ADD;
            end
            OPC_SLTI: begin
                op1  = rs_val;
                op2  = imm_sx;
                s_op = ALU_SLT;
            end
            OPC_ANDI: begin
                op1  = rs_val;
                op2  = imm_zx;
                s_op = ALU_AND;
            end
            OPC_ORI: begin
                op1  = rs_val;
                op2  = imm_zx;
                s_op = ALU_OR;
            end
            OPC_LW, OPC_SW: begin
                op1  = rs_val;
                op2  = imm_sx;
                s_op = ALU_ADD;
            end
            OPC_BEQ: begin
                op1    = rs_val;
                op2    = rt_val;
                s_op   = ALU_SUB;
                is_beq = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue-and-capture stage: registers decoded operands toward the ALU, then captures its
// result one cycle later and holds it until the consumer accepts.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] Op1,
    output logic [31:0] Op2,
    output logic [3:0]  S_Op,
    input  logic [31:0] R_Op,
    input  logic        ZF,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        branch_taken,
    output logic        illegal,
    output logic        div_zero
);

    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic [3:0]  dec_s_op;
    logic        dec_is_beq;
    logic        dec_illegal;
    logic        dec_div_zero;

    alu_decode u_decode (
        .instr    (instr),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .op1      (dec_op1),
        .op2      (dec_op2),
        .s_op     (dec_s_op),
        .is_beq   (dec_is_beq),
        .illegal  (dec_illegal),
        .div_zero (dec_div_zero)
    );

    state_e      state_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [3:0]  s_op_q;
    logic        is_beq_q;
    logic        ill_pend_q;
    logic        dz_pend_q;
    logic [31:0] result_q;
    logic        zero_q;
    logic        branch_q;
    logic        illegal_q;
    logic        div_zero_q;

    // Flags decoded at accept wait in *_pend_q so the visible flags change with the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            s_op_q      <= ALU_SLL;
            is_beq_q    <= 1'b0;
            ill_pend_q  <= 1'b0;
            dz_pend_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= StExec;
                        in_ready_q <= 1'b0;
                        op1_q      <= dec_op1;
                        op2_q      <= dec_op2;
                        s_op_q     <= dec_s_op;
                        is_beq_q   <= dec_is_beq;
                        ill_pend_q <= dec_illegal;
                        dz_pend_q  <= dec_div_zero;
                    end
                end
                StExec: begin
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                    result_q    <= dz_pend_q ? 32'hFFFF_FFFF : R_Op;
                    zero_q      <= ZF;
                    branch_q    <= is_beq_q && ZF;
                    illegal_q   <= ill_pend_q;
                    div_zero_q  <= dz_pend_q;
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign Op1          = op1_q;
    assign Op2          = op2_q;
    assign S_Op         = s_op_q;
    assign result       = result_q;
    assign zero         = zero_q;
    assign branch_taken = branch_q;
    assign illegal      = illegal_q;
    assign div_zero     = div_zero_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural ALU closes the loop, and each instruction's outcome
// is predicted from MIPS semantics by an instruction-level reference model.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] Op1;
    logic [31:0] Op2;
    logic [3:0]  S_Op;
    logic [31:0] R_Op;
    logic        ZF;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        illegal;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .Op1          (Op1),
        .Op2          (Op2),
        .S_Op         (S_Op),
        .R_Op         (R_Op),
        .ZF           (ZF),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .div_zero     (div_zero)
    );

    // Stand-in for the existing 32-bit ALU.
    always_comb begin
        R_Op = '0;
        case (S_Op)
            ALU_ADD:  R_Op = Op1 + Op2;
            ALU_SUB:  R_Op = Op1 - Op2;
            ALU_MULT: R_Op = Op1 * Op2;
            ALU_DIV:  R_Op = (Op2 == 0) ? 32'hFFFF_FFFF : Op1 / Op2;
            ALU_OR:   R_Op = Op1 | Op2;
            ALU_AND:  R_Op = Op1 & Op2;
            ALU_SLT:  R_Op = (Op1 < Op2) ? 32'd1 : 32'd0;
            ALU_SLL:  R_Op = Op1 << Op2[4:0];
            ALU_ADDI: R_Op = Op1 + 32'd1;
            ALU_SLTI: R_Op = (Op1 < 32'd1) ? 32'd1 : 32'd0;
            ALU_ANDI: R_Op = Op1 & 32'h0000_00FF;
            ALU_ORI:  R_Op = Op1 | 32'h0000_00FF;
            default:  R_Op = '0;
        endcase
        ZF = (R_Op == 0);
    end

    typedef struct packed {
        logic [3:0]  sop;
        logic [31:0] o1;
        logic [31:0] o2;
        logic [31:0] res;
        logic        z;
        logic        br;
        logic        ill;
        logic        dz;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [31:0] sx;
        logic [31:0] zx;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        e  = '0;
        e.sop = 4'd7;
        case (ins[31:26])
            6'h00: begin
                e.o1 = a;
                e.o2 = b;
                case (ins[5:0])
                    6'h20: begin e.sop = 4'd0; e.res = a + b; end
                    6'h22: begin e.sop = 4'd1; e.res = a - b; end
                    6'h18: begin e.sop = 4'd2; e.res = a * b; end
                    6'h1a: begin
                        if (b == 0) begin
                            e.o1 = 0; e.o2 = 0; e.dz = 1'b1; e.res = 32'hFFFF_FFFF;
                        end else begin
                            e.sop = 4'd3; e.res = a / b;
                        end
                    end
                    6'h25: begin e.sop = 4'd4; e.res = a | b; end
                    6'h24: begin e.sop = 4'd5; e.res = a & b; end
                    6'h2a: begin e.sop = 4'd6; e.res = (a < b) ? 32'd1 : 32'd0; end
                    6'h00: begin e.sop = 4'd7; e.res = a << b[4:0]; end
                    default: begin e.o1 = 0; e.o2 = 0; e.ill = 1'b1; end
                endcase
            end
            6'h08:        begin e.sop = 4'd0; e.o1 = a; e.o2 = sx; e.res = a + sx; end
            6'h0a:        begin e.sop = 4'd6; e.o1 = a; e.o2 = sx; e.res = (a < sx) ? 1 : 0; end
            6'h0c:        begin e.sop = 4'd5; e.o1 = a; e.o2 = zx; e.res = a & zx; end
            6'h0d:        begin e.sop = 4'd4; e.o1 = a; e.o2 = zx; e.res = a | zx; end
            6'h23, 6'h2b: begin e.sop = 4'd0; e.o1 = a; e.o2 = sx; e.res = a + sx; end
            6'h04: begin
                e.sop = 4'd1; e.o1 = a; e.o2 = b; e.res = a - b; e.br = (a == b);
            end
            default: e.ill = 1'b1;
        endcase
        // Illegal and divide-by-zero run SLL 0,0 in the ALU, so its zero flag is set.
        e.z = e.dz ? 1'b1 : (e.res == 0);
        return e;
    endfunction

    logic [3:0]  obs_sop;
    logic [31:0] obs_o1;
    logic [31:0] obs_o2;
    logic        obs_ov_n;
    logic        obs_rdy_n;
    logic        obs_ov_n1;

    task automatic wait_ready();
        int k = 0;
        while (in_ready !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout in_ready=%b required 1", in_ready);
        end
    endtask

    // Accept at edge N, sample ALU-side registers after N and results after N+1.
    task automatic issue_start(input logic [31:0] ins, input logic [31:0] a,
                               input logic [31:0] b);
        wait_ready();
        in_valid = 1'b1; instr = ins; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        in_valid = 1'b0; instr = $urandom; rs_val = $urandom; rt_val = $urandom;
        obs_sop = S_Op; obs_o1 = Op1; obs_o2 = Op2; obs_ov_n = out_valid; obs_rdy_n = in_ready;
        @(posedge clk); #1;
        obs_ov_n1 = out_valid;
    endtask

    task automatic complete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++;
            $display("FAIL reset_hs got ready/valid=%b%b required 10", in_ready, out_valid); end
        n_vec++; if ({S_Op, Op1, Op2} !== {4'd7, 64'd0}) begin n_err++;
            $display("FAIL reset_ops got S_Op=%h Op1=%h Op2=%h required 7/0/0", S_Op, Op1, Op2); end
        n_vec++; if ({result, zero, branch_taken, illegal, div_zero} !== 36'd0) begin n_err++;
            $display("FAIL reset_out got result=%h z=%b br=%b ill=%b dz=%b required all 0",
                     result, zero, branch_taken, illegal, div_zero); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        issue_start({6'b001000, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd0);
        n_vec++; if (obs_sop !== 4'd0 || obs_o2 !== 32'hFFFF_FFFF) begin n_err++;
            $display("FAIL addi_ops got S_Op=%h Op2=%h required 0/ffffffff", obs_sop, obs_o2); end
        n_vec++; if (obs_ov_n !== 1'b0 || obs_rdy_n !== 1'b0 || obs_ov_n1 !== 1'b1) begin
            n_err++;
            $display("FAIL addi_timing got ov@N=%b rdy@N=%b ov@N+1=%b required 0 0 1",
                     obs_ov_n, obs_rdy_n, obs_ov_n1); end
        n_vec++; if (result !== 32'd4 || zero !== 1'b0) begin n_err++;
            $display("FAIL addi_result got %h z=%b required 4 z=0", result, zero); end
        complete();
    endtask

    task automatic test_beq();
        issue_start({6'b000100, 26'd0}, 32'h1234, 32'h1234);
        n_vec++; if (obs_sop !== 4'd1 || zero !== 1'b1 || branch_taken !== 1'b1) begin n_err++;
            $display("FAIL beq_taken got S_Op=%h z=%b br=%b required 1 1 1",
                     obs_sop, zero, branch_taken); end
        complete();
        issue_start({6'b000100, 26'd0}, 32'h1234, 32'h1235);
        n_vec++; if (branch_taken !== 1'b0 || result !== 32'hFFFF_FFFF || zero !== 1'b0) begin
            n_err++;
            $display("FAIL beq_not_taken got br=%b result=%h z=%b required 0 ffffffff 0",
                     branch_taken, result, zero); end
        complete();
    endtask

    task automatic test_div_zero();
        issue_start({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b011010}, 32'd7, 32'd0);
        n_vec++; if (obs_sop !== 4'd7 || obs_o1 !== 0 || obs_o2 !== 0) begin n_err++;
            $display("FAIL divz_ops got S_Op=%h Op1=%h Op2=%h required 7/0/0",
                     obs_sop, obs_o1, obs_o2); end
        n_vec++; if (div_zero !== 1'b1 || result !== 32'hFFFF_FFFF) begin n_err++;
            $display("FAIL divz_out got dz=%b result=%h required 1 ffffffff", div_zero, result); end
        complete();
        issue_start({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b011010}, 32'd100, 32'd7);
        n_vec++; if (obs_sop !== 4'd3 || result !== 32'd14 || div_zero !== 1'b0) begin n_err++;
            $display("FAIL div_ok got S_Op=%h result=%0d dz=%b required 3 14 0",
                     obs_sop, result, div_zero); end
        complete();
    endtask

    task automatic test_illegal();
        issue_start({6'b111111, 26'h155_5555}, 32'hDEAD_BEEF, 32'h1);
        n_vec++; if (obs_sop !== 4'd7 || obs_o1 !== 0 || obs_o2 !== 0) begin n_err++;
            $display("FAIL illegal_ops got S_Op=%h Op1=%h Op2=%h required 7/0/0",
                     obs_sop, obs_o1, obs_o2); end
        n_vec++; if (illegal !== 1'b1 || result !== 0 || zero !== 1'b1) begin n_err++;
            $display("FAIL illegal_out got ill=%b result=%h z=%b required 1 0 1",
                     illegal, result, zero); end
        complete();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        issue_start({6'b001101, 10'd0, 16'h00F0}, 32'h0000_0F00, 32'd0);
        held = result;
        n_vec++; if (held !== 32'h0000_0FF0) begin n_err++;
            $display("FAIL bp_result got %h required 00000ff0", held); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instr = {6'b001000, 10'd0, 16'h0001}; rs_val = $urandom;
            @(posedge clk); #1;
            n_vec++; if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0
                         || S_Op !== 4'd4) begin n_err++;
                $display("FAIL bp_hold cyc %0d got result=%h ov=%b rdy=%b S_Op=%h", i, result,
                         out_valid, in_ready, S_Op); end
        end
        in_valid = 1'b0;
        complete();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL bp_release got ov=%b rdy=%b required 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_exec();
        issue_start({6'b000000, 20'd0, 6'b011010}, 32'd9, 32'd0);
        complete();
        wait_ready();
        in_valid = 1'b1; instr = {6'b000100, 26'd0}; rs_val = 32'd3; rt_val = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_vec++; if ({out_valid, in_ready, S_Op} !== {1'b0, 1'b1, 4'd7}) begin n_err++;
            $display("FAIL rst_exec_hs got ov=%b rdy=%b S_Op=%h required 0 1 7",
                     out_valid, in_ready, S_Op); end
        n_vec++; if ({result, zero, branch_taken, illegal, div_zero} !== 36'd0) begin n_err++;
            $display("FAIL rst_exec_out got result=%h z=%b br=%b ill=%b dz=%b required 0",
                     result, zero, branch_taken, illegal, div_zero); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_exec_noresult got ov=%b required 0", out_valid); end
    endtask

    task automatic test_random();
        logic [5:0]  opcs [11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                                   6'h23, 6'h2b, 6'h04, 6'h3f};
        logic [5:0]  fns  [9]  = '{6'h20, 6'h22, 6'h18, 6'h1a, 6'h25, 6'h24, 6'h2a,
                                   6'h00, 6'h3e};
        logic [31:0] r;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        for (int i = 0; i < 60; i++) begin
            r   = $urandom;
            ins = {opcs[$urandom_range(0, 10)], r[25:6], fns[$urandom_range(0, 8)]};
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'd0 : a)
                                              : $urandom_range(0, 40000);
            e   = model(ins, a, b);
            issue_start(ins, a, b);
            n_vec++; if ({obs_sop, obs_o1, obs_o2} !== {e.sop, e.o1, e.o2}) begin n_err++;
                $display("FAIL rand_ops ins=%h got %h/%h/%h required %h/%h/%h", ins,
                         obs_sop, obs_o1, obs_o2, e.sop, e.o1, e.o2); end
            n_vec++; if (obs_ov_n1 !== 1'b1 || result !== e.res) begin n_err++;
                $display("FAIL rand_result ins=%h a=%h b=%h got %h ov=%b required %h", ins, a,
                         b, result, obs_ov_n1, e.res); end
            n_vec++; if ({zero, branch_taken, illegal, div_zero} !== {e.z, e.br, e.ill, e.dz})
            begin n_err++;
                $display("FAIL rand_flags ins=%h got z/br/ill/dz=%b%b%b%b required %b%b%b%b",
                         ins, zero, branch_taken, illegal, div_zero, e.z, e.br, e.ill, e.dz);
            end
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            complete();
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_beq();
        test_div_zero();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
